vec_quad_stream: RTL and testbench

//  Streaming vector kernel: for i in 0..n-1 computes c[i] = (a[i] + K1*b[i]) * (a[i] + K2*b[i]),

---
 rtl/vec_quad_stream.sv | 146 ++++++++++++++
 tb/tb_vec_quad_stream.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vec_quad_stream.sv
// Streaming kernel c[i] = (a + K1*b) * (a + K2*b), optionally added onto c_in[i].
// Three-stage pipeline with valid/ready handshakes, one global stall and a job-level FSM.
module vec_quad_stream #(
    parameter int          W     = 32,
    parameter int unsigned K1    = 2,
    parameter int unsigned K2    = 5,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n,
    input  logic             acc_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a_data,
    input  logic [W-1:0]     b_data,
    input  logic [W-1:0]     c_data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     c_data_out,
    output logic             busy,
    output logic             done
);

    localparam logic [W-1:0] L_K1 = W'(K1);
    localparam logic [W-1:0] L_K2 = W'(K2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_n;
    logic             r_acc;
    logic [CNT_W-1:0] r_inCnt;
    logic [CNT_W-1:0] r_outCnt;

    logic             r_s1Valid;
    logic [W-1:0]     r_s1Sum1;
    logic [W-1:0]     r_s1Sum2;
    logic [W-1:0]     r_s1Cin;
    logic             r_s2Valid;
    logic [W-1:0]     r_s2Prod;
    logic [W-1:0]     r_s2Cin;
    logic             r_s3Valid;
    logic [W-1:0]     r_s3Res;

    logic             w_adv;
    logic             w_inFire;
    logic             w_outFire;
    logic             w_lastOut;
    logic [W-1:0]     w_sum1;
    logic [W-1:0]     w_sum2;
    logic [W-1:0]     w_prod;
    logic [W-1:0]     w_res;

    // The whole pipe moves together; it only freezes when the output beat is held.
    assign w_adv     = !r_s3Valid || out_ready;
    assign in_ready  = (r_state == S_RUN) && (r_inCnt < r_n) && w_adv;
    assign w_inFire  = in_valid && in_ready;
    assign w_outFire = r_s3Valid && out_ready;
    assign w_lastOut = w_outFire && ((r_outCnt + CNT_W'(1)) == r_n);

    assign w_sum1 = a_data + L_K1 * b_data;
    assign w_sum2 = a_data + L_K2 * b_data;
    assign w_prod = r_s1Sum1 * r_s1Sum2;
    assign w_res  = r_acc ? (r_s2Cin + r_s2Prod) : r_s2Prod;

    assign out_valid  = r_s3Valid;
    assign c_data_out = r_s3Res;
    assign busy       = (r_state == S_RUN) || (r_state == S_DONE);
    assign done       = (r_state == S_DONE);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = (n == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_lastOut) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_n      <= '0;
            r_acc    <= 1'b0;
            r_inCnt  <= '0;
            r_outCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if ((r_state == S_IDLE) && start) begin
                r_n      <= n;
                r_acc    <= acc_mode;
                r_inCnt  <= '0;
                r_outCnt <= '0;
            end else begin
                if (w_inFire) begin
                    r_inCnt <= r_inCnt + CNT_W'(1);
                end
                if (w_outFire) begin
                    r_outCnt <= r_outCnt + CNT_W'(1);
                end
            end
        end
    end

    // Data registers also clear on reset so the output bus reads zero afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1Valid <= 1'b0;
            r_s1Sum1  <= '0;
            r_s1Sum2  <= '0;
            r_s1Cin   <= '0;
            r_s2Valid <= 1'b0;
            r_s2Prod  <= '0;
            r_s2Cin   <= '0;
            r_s3Valid <= 1'b0;
            r_s3Res   <= '0;
        end else if (w_adv) begin
            r_s1Valid <= w_inFire;
            r_s1Sum1  <= w_sum1;
            r_s1Sum2  <= w_sum2;
            r_s1Cin   <= c_data_in;
            r_s2Valid <= r_s1Valid;
            r_s2Prod  <= w_prod;
            r_s2Cin   <= r_s1Cin;
            r_s3Valid <= r_s2Valid;
            r_s3Res   <= w_res;
        end
    end

endmodule

// File: tb/tb_vec_quad_stream.sv
// Directed bench for vec_quad_stream: 32-bit default instance plus an 8-bit instance
// for the modulo-width case; expected results are hand-computed constants.
module tb_vec_quad_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] n;
    logic        acc_mode;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_data;
    logic [31:0] b_data;
    logic [31:0] c_data_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c_data_out;
    logic        busy;
    logic        done;

    logic        start8;
    logic [15:0] n8;
    logic        accMode8;
    logic        inValid8;
    logic        inReady8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [7:0]  cin8;
    logic        outValid8;
    logic        outReady8;
    logic [7:0]  c8;
    logic        busy8;
    logic        done8;

    int errors = 0;
    int checks = 0;

    logic [31:0] aVec   [4];
    logic [31:0] bVec   [4];
    logic [31:0] cinVec [4];
    logic [31:0] expVec [4];

    vec_quad_stream dut (
        .clk(clk), .rst(rst), .start(start), .n(n), .acc_mode(acc_mode),
        .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .b_data(b_data),
        .c_data_in(c_data_in), .out_valid(out_valid), .out_ready(out_ready),
        .c_data_out(c_data_out), .busy(busy), .done(done)
    );

    vec_quad_stream #(.W(8), .K1(2), .K2(5), .CNT_W(16)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .n(n8), .acc_mode(accMode8),
        .in_valid(inValid8), .in_ready(inReady8), .a_data(a8), .b_data(b8),
        .c_data_in(cin8), .out_valid(outValid8), .out_ready(outReady8),
        .c_data_out(c8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One complete job on the 32-bit instance, driving inputs and checking outputs cycle by cycle.
    task automatic applyStimulus(input int nn, input logic acc, input logic stall, input string tag);
        int          inIdx = 0;
        int          outIdx = 0;
        int          firstAcc = -1;
        int          firstOut = -1;
        int          doneCnt = 0;
        int          doneCyc = -1;
        int          lastOutCyc = -1;
        logic        prevStall = 1'b0;
        logic [31:0] prevData = '0;
        logic        finished = 1'b0;

        @(negedge clk);
        start = 1'b1; n = 16'(nn); acc_mode = acc; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 16'(nn + 3);
        #1;
        checkOutput({tag, ".busyAfterStart"}, {63'd0, busy}, 64'd1);
        for (int cyc = 0; cyc < 80 && !finished; cyc++) begin
            if (cyc > 0) @(negedge clk);
            out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            in_valid  = 1'b1;
            a_data    = (inIdx < nn) ? aVec[inIdx]   : 32'hDEAD;
            b_data    = (inIdx < nn) ? bVec[inIdx]   : 32'hBEEF;
            c_data_in = (inIdx < nn) ? cinVec[inIdx] : 32'h1234;
            #1;
            if (prevStall) begin
                checkOutput({tag, ".holdValid"}, {63'd0, out_valid}, 64'd1);
                checkOutput({tag, ".holdData"}, {32'd0, c_data_out}, {32'd0, prevData});
            end
            if (out_valid && !out_ready)
                checkOutput({tag, ".stallInReady"}, {63'd0, in_ready}, 64'd0);
            if (inIdx >= nn)
                checkOutput({tag, ".noExtraAccept"}, {63'd0, in_ready}, 64'd0);
            if (in_valid && in_ready) begin
                if (firstAcc < 0) firstAcc = cyc;
                inIdx++;
            end
            if (out_valid && firstOut < 0) firstOut = cyc;
            if (out_valid && out_ready) begin
                if (outIdx < nn)
                    checkOutput($sformatf("%s.c[%0d]", tag, outIdx), {32'd0, c_data_out}, {32'd0, expVec[outIdx]});
                else
                    checkOutput({tag, ".extraBeat"}, 64'(outIdx), 64'(nn));
                outIdx++;
                lastOutCyc = cyc;
            end
            if (done) begin
                doneCnt++;
                doneCyc  = cyc;
                finished = 1'b1;
            end
            prevStall = out_valid && !out_ready;
            prevData  = c_data_out;
            @(posedge clk);
        end
        checkOutput({tag, ".finished"}, {63'd0, finished}, 64'd1);
        checkOutput({tag, ".inCount"}, 64'(inIdx), 64'(nn));
        checkOutput({tag, ".outCount"}, 64'(outIdx), 64'(nn));
        checkOutput({tag, ".doneCount"}, 64'(doneCnt), 64'd1);
        if (nn > 0) begin
            checkOutput({tag, ".latency"}, 64'(firstOut - firstAcc), 64'd3);
            checkOutput({tag, ".doneGap"}, 64'(doneCyc - lastOutCyc), 64'd1);
        end else begin
            checkOutput({tag, ".zeroDoneCycle"}, 64'(doneCyc), 64'd0);
            checkOutput({tag, ".zeroNoOutput"}, 64'(firstOut), -64'sd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkOutput({tag, ".doneDropped"}, {63'd0, done}, 64'd0);
        checkOutput({tag, ".idleNotBusy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int accepted;
        logic got8;
        logic done8Seen;

        rst = 1'b0; start = 1'b0; n = '0; acc_mode = 1'b0; in_valid = 1'b0;
        a_data = '0; b_data = '0; c_data_in = '0; out_ready = 1'b1;
        start8 = 1'b0; n8 = '0; accMode8 = 1'b0; inValid8 = 1'b0;
        a8 = '0; b8 = '0; cin8 = '0; outReady8 = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("reset.inReady", {63'd0, in_ready}, 64'd0);
        checkOutput("reset.outValid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset.data", {32'd0, c_data_out}, 64'd0);
        checkOutput("reset.busy", {63'd0, busy}, 64'd0);
        checkOutput("reset.done", {63'd0, done}, 64'd0);
        rst = 1'b1;

        $display("[TB] scenario 1: plain job n=4");
        aVec = '{32'd10, 32'd20, 32'd30, 32'd40};
        bVec = '{32'd2, 32'd3, 32'd4, 32'd5};
        cinVec = '{32'd1000, 32'd1000, 32'd1000, 32'd1000};
        expVec = '{32'd280, 32'd910, 32'd1900, 32'd3250};
        applyStimulus(4, 1'b0, 1'b0, "s1");

        $display("[TB] scenario 2: accumulate mode");
        expVec = '{32'd1280, 32'd1910, 32'd2900, 32'd4250};
        applyStimulus(4, 1'b1, 1'b0, "s2");

        $display("[TB] scenario 3: output backpressure");
        expVec = '{32'd280, 32'd910, 32'd1900, 32'd3250};
        applyStimulus(4, 1'b0, 1'b1, "s3");

        $display("[TB] scenario 4: empty job");
        applyStimulus(0, 1'b0, 1'b0, "s4");

        $display("[TB] scenario 5: 8-bit instance wraps modulo 256");
        @(negedge clk);
        start8 = 1'b1; n8 = 16'd1;
        @(negedge clk);
        start8 = 1'b0; inValid8 = 1'b1; a8 = 8'd100; b8 = 8'd10;
        got8 = 1'b0; done8Seen = 1'b0;
        for (int k = 0; k < 20 && !done8Seen; k++) begin
            #1;
            if (outValid8 && !got8) begin
                checkOutput("s5.c", {56'd0, c8}, 64'd80);
                got8 = 1'b1;
            end
            if (done8) done8Seen = 1'b1;
            if (inValid8 && inReady8) begin
                @(negedge clk);
                inValid8 = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        checkOutput("s5.gotResult", {63'd0, got8}, 64'd1);
        checkOutput("s5.doneSeen", {63'd0, done8Seen}, 64'd1);

        $display("[TB] scenario 6: reset mid-job");
        @(negedge clk);
        start = 1'b1; n = 16'd4; acc_mode = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        accepted = 0;
        for (int k = 0; k < 10 && accepted < 2; k++) begin
            in_valid = 1'b1;
            a_data = aVec[accepted]; b_data = bVec[accepted]; c_data_in = cinVec[accepted];
            #1;
            if (in_valid && in_ready) accepted++;
            @(negedge clk);
        end
        checkOutput("s6.twoAccepted", 64'(accepted), 64'd2);
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("s6.rstInReady", {63'd0, in_ready}, 64'd0);
        checkOutput("s6.rstOutValid", {63'd0, out_valid}, 64'd0);
        checkOutput("s6.rstData", {32'd0, c_data_out}, 64'd0);
        checkOutput("s6.rstBusy", {63'd0, busy}, 64'd0);
        checkOutput("s6.rstDone", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(4, 1'b0, 1'b0, "s6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
